// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//   Arbitrates NREQ word-producing requesters onto the write side of a single
//   downstream FIFO. One requester owns the FIFO at a time and may push up to
//   BURST words per grant. Each word is acknowledged combinationally and
//   written one cycle later. Writes stall while the FIFO lacks headroom.
//   Arbitration is round-robin by default.
//
//   Build option:
//     FIFO_WR_ARB_FIXPRIO_EN  when defined, the lowest requester index always
//                             wins. The round-robin pointer is held at 0.
//
//   Ports:
//     clk         in   clock
//     rst_n       in   asynchronous active-low reset
//     req         in   [NREQ]        requester i has a valid word
//     data        in   [NREQ*WIDTH]  lane i at bits [i*WIDTH +: WIDTH]
//     ack         out  [NREQ]        word on lane i accepted this cycle
//     grant       out  [NREQ]        one-hot current owner, or zero
//     busy        out                a grant is active
//     fifo_full   in                 FIFO full flag
//     fifo_usedw  in   [UWIDTH]      FIFO used-words count
//     fifo_write  out                FIFO write strobe (registered)
//     fifo_data   out  [WIDTH]       FIFO write data (registered)
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 16,
  parameter int SIZE   = 32,
  parameter int BURST  = 8,
  parameter int UWIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  input  logic                  fifo_full,
  input  logic [UWIDTH-1:0]     fifo_usedw,
  output logic                  fifo_write,
  output logic [WIDTH-1:0]      fifo_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Two words of margin: one write is already registered and in flight when
  // usedw is sampled, and one more may be accepted this cycle.
  localparam logic [UWIDTH:0] ROOM_LIM = (UWIDTH + 1)'(SIZE - 2);
  localparam logic [7:0]      LAST_CNT = 8'(BURST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             fifo_write_q, fifo_write_d;
  logic [WIDTH-1:0] fifo_data_q, fifo_data_d;

  logic             room;
  logic             own_req;
  logic             accept;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic [WIDTH-1:0] lane_data;

  // (base + off) mod NREQ, for off in 0..NREQ-1.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  assign room = !fifo_full && ({1'b0, fifo_usedw} < ROOM_LIM);
  assign busy = (state_q == ST_GRANT);

  // Requester selection: first set req bit searching upward from the base.
  always_comb begin
    logic [IW-1:0] base;
    logic [IW-1:0] idx;
    // NOTE: every variable written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef FIFO_WR_ARB_FIXPRIO_EN
    base      = '0;
`else
    base      = ptr_q;
`endif
    for (int i = 0; i < NREQ; i++) begin
      idx = wrap_idx(base, i);
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Owner decode: grant vector, owner request and owner data lane.
  always_comb begin
    grant     = '0;
    lane_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        grant[i]  = busy;
        lane_data = data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign own_req = |(req & grant);
  assign accept  = own_req && room;
  assign ack     = accept ? grant : '0;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    fifo_write_d = 1'b0;
    fifo_data_d  = fifo_data_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d = ST_GRANT;
          owner_d = sel_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          fifo_write_d = 1'b1;
          fifo_data_d  = lane_data;
          cnt_d        = cnt_q + 8'd1;
        end
        // Release when the owner withdraws or its last allowed word is taken.
        // A stalled owner (req high, no room) keeps the grant.
        if (!own_req || (accept && (cnt_q == LAST_CNT))) begin
          state_d = ST_IDLE;
`ifdef FIFO_WR_ARB_FIXPRIO_EN
          ptr_d   = '0;
`else
          ptr_d   = wrap_idx(owner_q, 1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

  assign fifo_write = fifo_write_q;
  assign fifo_data  = fifo_data_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
//   Self-checking bench for fifo_wr_arb. Two instances share clock and reset:
//   u_dut8 (BURST=8) and u_dut2 (BURST=2). A negedge monitor per instance
//   pushes the acknowledged lane word into a scoreboard queue and pops it
//   when fifo_write appears, and logs grant owners, burst lengths and idle
//   gaps for the directed scenarios driven from the main initial block.
//   Define FIFO_WR_ARB_FIXPRIO_EN for both files to check the fixed-priority
//   build.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 16;
  localparam int SIZE   = 32;
  localparam int UWIDTH = $clog2(SIZE);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       req        [2];
  logic [NREQ-1:0]       ack        [2];
  logic [NREQ-1:0]       grant      [2];
  logic                  busy       [2];
  logic                  fifo_full  [2];
  logic [UWIDTH-1:0]     fifo_usedw [2];
  logic                  fifo_write [2];
  logic [WIDTH-1:0]      fifo_data  [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] sb     [2][$];
  int               go_q   [2][$];
  int               bl_q   [2][$];
  int               gap_q  [2][$];
  int               ack_cnt[2];
  int               wr_cnt [2];
  int               b_acks [2];
  int               idle_run[2];
  logic [NREQ-1:0]  prev_grant[2];

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .SIZE(SIZE), .BURST(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .data(data), .ack(ack[0]),
    .grant(grant[0]), .busy(busy[0]), .fifo_full(fifo_full[0]),
    .fifo_usedw(fifo_usedw[0]), .fifo_write(fifo_write[0]), .fifo_data(fifo_data[0])
  );

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .SIZE(SIZE), .BURST(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .data(data), .ack(ack[1]),
    .grant(grant[1]), .busy(busy[1]), .fifo_full(fifo_full[1]),
    .fifo_usedw(fifo_usedw[1]), .fifo_write(fifo_write[1]), .fifo_data(fifo_data[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Advance to just after the next rising edge and present fresh lane data.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = WIDTH'($urandom());
  endtask

  task automatic clr(input int k);
    go_q[k].delete();
    bl_q[k].delete();
    gap_q[k].delete();
  endtask

  task automatic wait_grants(input int k, input int n, input int lim, input string tag);
    int c = 0;
    while (go_q[k].size() < n && c < lim) begin cyc(); c++; end
    if (go_q[k].size() < n) check(tag, 64'(go_q[k].size()), 64'(n));
  endtask

  task automatic wait_bursts(input int k, input int n, input int lim, input string tag);
    int c = 0;
    while (bl_q[k].size() < n && c < lim) begin cyc(); c++; end
    if (bl_q[k].size() < n) check(tag, 64'(bl_q[k].size()), 64'(n));
  endtask

  task automatic wait_cnt(input bit use_wr, input int target, input int lim, input string tag);
    int c = 0;
    while (((use_wr ? wr_cnt[0] : ack_cnt[0]) < target) && c < lim) begin cyc(); c++; end
    if ((use_wr ? wr_cnt[0] : ack_cnt[0]) < target) check(tag, 64'(use_wr ? wr_cnt[0] : ack_cnt[0]), 64'(target));
  endtask

  // Scoreboard and grant-history monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check($sformatf("reset_quiet%0d", k), {60'd0, fifo_write[k], |ack[k], busy[k], |grant[k]}, 64'd0);
        prev_grant[k] = '0;
        idle_run[k]   = 0;
      end else begin
        check($sformatf("busy_vs_grant%0d", k), 64'(busy[k]), 64'(|grant[k]));
        if (fifo_write[k]) begin
          wr_cnt[k]++;
          if (sb[k].size() == 0) check($sformatf("unexpected_write%0d", k), 64'd1, 64'd0);
          else check($sformatf("fifo_data%0d", k), 64'(fifo_data[k]), 64'(sb[k].pop_front()));
        end
        if (grant[k] != '0 && prev_grant[k] == '0) begin
          go_q[k].push_back(oh2i(grant[k]));
          gap_q[k].push_back(idle_run[k]);
          b_acks[k] = 0;
        end
        if (grant[k] == '0 && prev_grant[k] != '0) bl_q[k].push_back(b_acks[k]);
        if (grant[k] == '0) idle_run[k]++;
        else idle_run[k] = 0;
        if (ack[k] != '0) begin
          check($sformatf("ack_onehot%0d", k), 64'($onehot(ack[k])), 64'd1);
          check($sformatf("ack_in_grant%0d", k), 64'(ack[k] & ~grant[k]), 64'd0);
          sb[k].push_back(data[oh2i(ack[k])*WIDTH +: WIDTH]);
          ack_cnt[k]++;
          b_acks[k]++;
        end
        prev_grant[k] = grant[k];
      end
    end
  end

  initial begin
    int base;
    int exp_rr[5];
    int exp_ptr3;
    int exp_fix[3];
`ifdef FIFO_WR_ARB_FIXPRIO_EN
    exp_rr   = '{0, 0, 0, 0, 0};
    exp_ptr3 = 0;
    exp_fix  = '{1, 1, 1};
`else
    exp_rr   = '{0, 1, 2, 3, 0};
    exp_ptr3 = 3;
    exp_fix  = '{3, 1, 3};
`endif
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; fifo_full[k] = 1'b0; fifo_usedw[k] = '0;
      ack_cnt[k] = 0; wr_cnt[k] = 0; b_acks[k] = 0; idle_run[k] = 0; prev_grant[k] = '0;
    end
    data  = '0;
    rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_grant", 64'(grant[0]), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_fifo_write", 64'(fifo_write[0]), 64'd0);
    check("rst_fifo_data", 64'(fifo_data[0]), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Single requester, full burst of 8, one idle cycle, regrant.
    clr(0);
    req[0] = 4'b0001;
    wait_grants(0, 2, 40, "t1_timeout");
    req[0] = '0;
    repeat (3) cyc();
    check("t1_owner0", 64'(at(go_q[0], 0)), 64'd0);
    check("t1_burst_len", 64'(at(bl_q[0], 0)), 64'd8);
    check("t1_idle_gap", 64'(at(gap_q[0], 1)), 64'd1);
    check("t1_regrant", 64'(at(go_q[0], 1)), 64'd0);

    // Round-robin on the BURST=2 instance.
    clr(1);
    req[1] = 4'b1111;
    wait_grants(1, 5, 80, "t2_timeout");
    req[1] = '0;
    repeat (3) cyc();
    for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), 64'(at(go_q[1], i)), 64'(exp_rr[i]));
    for (int i = 0; i < 4; i++) check($sformatf("t2_len%0d", i), 64'(at(bl_q[1], i)), 64'd2);

    // Backpressure: stall at usedw 30, accept at 29, stall on full.
    clr(0);
    req[0] = 4'b0010;
    base = ack_cnt[0];
    wait_cnt(1'b0, base + 2, 30, "t3_start_timeout");
    fifo_usedw[0] = UWIDTH'(30);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_stall_ack", 64'(ack[0]), 64'd0);
      check("t3_stall_busy", 64'(busy[0]), 64'd1);
      cyc();
    end
    check("t3_stall_count", 64'(ack_cnt[0] - base), 64'd2);
    fifo_usedw[0] = UWIDTH'(29);
    #1;
    check("t3_usedw29_ack", 64'(ack[0]), 64'b0010);
    cyc();
    fifo_usedw[0] = '0;
    fifo_full[0]  = 1'b1;
    #1;
    check("t3_full_ack", 64'(ack[0]), 64'd0);
    cyc();
    fifo_full[0]  = 1'b0;
    fifo_usedw[0] = UWIDTH'(10);
    wait_bursts(0, 1, 40, "t3_timeout");
    req[0] = '0;
    fifo_usedw[0] = '0;
    repeat (3) cyc();
    check("t3_owner1", 64'(at(go_q[0], 0)), 64'd1);
    check("t3_total_words", 64'(at(bl_q[0], 0)), 64'd8);

    // Early release after 3 words, then pointer lands on 3.
    clr(0);
    req[0] = 4'b0100;
    base = ack_cnt[0];
    wait_cnt(1'b0, base + 3, 30, "t4_start_timeout");
    req[0] = '0;
    repeat (2) cyc();
    check("t4_owner2", 64'(at(go_q[0], 0)), 64'd2);
    check("t4_burst_len", 64'(at(bl_q[0], 0)), 64'd3);
    check("t4_busy_off", 64'(busy[0]), 64'd0);
    req[0] = 4'b1111;
    wait_grants(0, 2, 20, "t4_regrant_timeout");
    check("t4_ptr_next", 64'(at(go_q[0], 1)), 64'(exp_ptr3));

    // Reset during that burst.
    base = wr_cnt[0];
    wait_cnt(1'b1, base + 3, 30, "t5_start_timeout");
    rst_n = 1'b0;
    #1;
    check("t5_grant", 64'(grant[0]), 64'd0);
    check("t5_busy", 64'(busy[0]), 64'd0);
    check("t5_fifo_write", 64'(fifo_write[0]), 64'd0);
    check("t5_fifo_data", 64'(fifo_data[0]), 64'd0);
    check("t5_ack", 64'(ack[0]), 64'd0);
    sb[0].delete();
    req[0] = 4'b1100;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check("t5_first_arb_grant", 64'(grant[0]), 64'b0100);
    check("t5_first_arb_busy", 64'(busy[0]), 64'd1);
    req[0] = '0;
    repeat (3) cyc();

    // Two contenders, 1 and 3.
    clr(0);
    req[0] = 4'b1010;
    wait_grants(0, 3, 60, "t6_timeout");
    req[0] = '0;
    repeat (4) cyc();
    for (int i = 0; i < 3; i++) check($sformatf("t6_order%0d", i), 64'(at(go_q[0], i)), 64'(exp_fix[i]));

    check("sb_drain0", 64'(sb[0].size()), 64'd0);
    check("sb_drain1", 64'(sb[1].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
